// File: rtl/prim_slot_allocator_64.sv
// 64-slot busy/free tracker handing out one free 6-bit slot index per cycle.
// Ports: i_clk/i_rst, i_flush, alloc req/gnt/idx, free vld/idx, busy_vec, free_cnt, full/empty, free_err.
module prim_slot_allocator_64 #(
   parameter logic RR_POLICY = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_alloc_req,
   output logic        o_alloc_gnt,
   output logic [5:0]  o_alloc_idx,
   input  logic        i_free_vld,
   input  logic [5:0]  i_free_idx,
   output logic [63:0] o_busy_vec,
   output logic [6:0]  o_free_cnt,
   output logic        o_full,
   output logic        o_empty,
   output logic        o_free_err
);

   logic [63:0] busy;
   logic [6:0]  cnt;
   logic [5:0]  rr_last;
   logic        err;

   logic [5:0]  start;
   logic [5:0]  cand;
   logic [5:0]  pick;
   logic        found;
   logic        gnt;
   logic        free_ok;
   logic [63:0] set_mask;
   logic [63:0] clr_mask;

   // Circular search over the registered busy map; start is 0 for
   // lowest-first, or one past the last grant for round-robin.
   always_comb begin
      start = RR_POLICY ? rr_last + 6'd1 : 6'd0;
      pick  = 6'd0;
      found = 1'b0;
      cand  = 6'd0;
      for (int k = 0; k < 64; k++) begin
         cand = start + 6'(k);
         if (!found && !busy[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign o_full  = (cnt == 7'd0);
   assign o_empty = (cnt == 7'd64);

   assign gnt = i_alloc_req & ~o_full & ~i_flush & ~i_rst & found;

   assign o_alloc_gnt = gnt;
   assign o_alloc_idx = gnt ? pick : 6'd0;

   // Only a busy slot can be cleared, so set/clear never collide.
   assign free_ok  = i_free_vld & busy[i_free_idx];
   assign set_mask = gnt ? (64'd1 << pick) : 64'd0;
   assign clr_mask = free_ok ? (64'd1 << i_free_idx) : 64'd0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy    <= 64'd0;
         cnt     <= 7'd64;
         rr_last <= 6'd63;
         err     <= 1'b0;
      end else if (i_flush) begin
         busy <= 64'd0;
         cnt  <= 7'd64;
         err  <= 1'b0;
      end else begin
         busy <= (busy | set_mask) & ~clr_mask;
         cnt  <= cnt - {6'd0, gnt} + {6'd0, free_ok};
         err  <= i_free_vld & ~busy[i_free_idx];
         if (RR_POLICY && gnt) begin
            rr_last <= pick;
         end
      end
   end

   assign o_busy_vec = busy;
   assign o_free_cnt = cnt;
   assign o_free_err = err;

endmodule
